biu2: RTL and testbench

BIU2 -- requirements
Module: biu2

---
 rtl/biu2.sv | 185 ++++++++++++++++++
 tb/tb_biu2.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu2.sv
// ---------------------------------------------------------------------------
// biu2 - bus interface unit for a small core.
//
// Routes the core's single data port to one of three targets:
//   ITIM  : zero-wait, read-only from the data side (writes raise a fault)
//   DTIM  : zero-wait read/write, never stalls the core
//   MMIO  : handshaked request/ready bus with a bounded wait (timeout)
// Accesses outside every region raise a fault and read DEFAULT_RDATA.
// The instruction fetch path is a combinational pass-through to the ITIM.
//
// Ports
//   clk, rst                : clock, asynchronous active-low reset
//   biu_i_iaddr/biu_o_idata : instruction fetch address / data
//   biu_i_d*                : core data request (dwmask == 0 means read)
//   biu_o_drdata            : read data returned to the core
//   biu_o_halt              : stall request while an MMIO access is open
//   biu_o_fault             : one-cycle access-fault pulse
//   biu_o_itim_* / biu_i_itim_rdata : ITIM macro port
//   biu_o_dtim_* / biu_i_dtim_rdata : DTIM macro port
//   biu_o_mmio_* / biu_i_mmio_*     : MMIO request/ready bus
//
// MMIO FSM states
//   state  | meaning
//   IDLE   | no MMIO access open; decodes the core request
//   REQ    | mmio_valid high, waiting for ready or timeout
//   DONE   | captured data presented to the core, halt released
// ---------------------------------------------------------------------------
module biu2 #(
    parameter int          TIM_AW        = 12,
    parameter logic [31:0] ITIM_BASE     = 32'h0000_0000,
    parameter logic [31:0] DTIM_BASE     = 32'h0000_1000,
    parameter logic [31:0] MMIO_BASE     = 32'h0000_2000,
    parameter logic [31:0] MMIO_SIZE     = 32'h0000_1000,
    parameter int          TIMEOUT       = 255,
    parameter logic [31:0] DEFAULT_RDATA = 32'hCCCC_CCCC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       biu_i_iaddr,
    output logic [31:0]       biu_o_idata,
    input  logic              biu_i_dreq,
    input  logic [31:0]       biu_i_daddr,
    input  logic [3:0]        biu_i_dwmask,
    input  logic [31:0]       biu_i_dwdata,
    output logic [31:0]       biu_o_drdata,
    output logic              biu_o_halt,
    output logic              biu_o_fault,
    output logic [TIM_AW-1:0] biu_o_itim_addr,
    input  logic [31:0]       biu_i_itim_rdata,
    output logic [TIM_AW-1:0] biu_o_dtim_addr,
    output logic [3:0]        biu_o_dtim_wmask,
    output logic [31:0]       biu_o_dtim_wdata,
    input  logic [31:0]       biu_i_dtim_rdata,
    output logic              biu_o_mmio_valid,
    output logic [31:0]       biu_o_mmio_addr,
    output logic [3:0]        biu_o_mmio_wmask,
    output logic [31:0]       biu_o_mmio_wdata,
    input  logic              biu_i_mmio_ready,
    input  logic [31:0]       biu_i_mmio_rdata
);

    localparam int          CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [32:0] TIM_SIZE = 33'd1 << TIM_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            fault_q, fault_d;

    logic            in_itim, in_dtim, in_mmio, unmapped, is_write;
    logic            st_idle, st_req, st_done;

    // Region decode in 33 bits so base+size cannot overflow at the top of
    // the address space.
    always_comb begin
        in_itim  = ({1'b0, biu_i_daddr} >= {1'b0, ITIM_BASE}) &&
                   ({1'b0, biu_i_daddr} <  ({1'b0, ITIM_BASE} + TIM_SIZE));
        in_dtim  = ({1'b0, biu_i_daddr} >= {1'b0, DTIM_BASE}) &&
                   ({1'b0, biu_i_daddr} <  ({1'b0, DTIM_BASE} + TIM_SIZE));
        in_mmio  = ({1'b0, biu_i_daddr} >= {1'b0, MMIO_BASE}) &&
                   ({1'b0, biu_i_daddr} <  ({1'b0, MMIO_BASE} + {1'b0, MMIO_SIZE}));
        unmapped = !(in_itim || in_dtim || in_mmio);
        is_write = (biu_i_dwmask != 4'h0);
    end

    assign st_idle = (state_q == S_IDLE);
    assign st_req  = (state_q == S_REQ);
    assign st_done = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (biu_i_dreq && in_mmio) begin
                    addr_d  = biu_i_daddr - MMIO_BASE;
                    wmask_d = biu_i_dwmask;
                    wdata_d = biu_i_dwdata;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // ready in the last allowed cycle still completes cleanly
                if (biu_i_mmio_ready) begin
                    rdata_d = biu_i_mmio_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = DEFAULT_RDATA;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign biu_o_itim_addr  = TIM_AW'(biu_i_iaddr - ITIM_BASE);
    assign biu_o_idata      = biu_i_itim_rdata;

    assign biu_o_dtim_addr  = TIM_AW'(biu_i_daddr - DTIM_BASE);
    assign biu_o_dtim_wmask = (biu_i_dreq && in_dtim) ? biu_i_dwmask : 4'h0;
    assign biu_o_dtim_wdata = biu_i_dwdata;

    assign biu_o_mmio_valid = st_req;
    assign biu_o_mmio_addr  = addr_q;
    assign biu_o_mmio_wmask = st_req ? wmask_q : 4'h0;
    assign biu_o_mmio_wdata = wdata_q;

    // The IDLE-cycle halt and decode faults are combinational on the core
    // request, so they are qualified with rst to stay low during reset.
    assign biu_o_halt  = rst && (st_req || (st_idle && biu_i_dreq && in_mmio));
    assign biu_o_fault = fault_q ||
                         (rst && st_idle && biu_i_dreq && (unmapped || (in_itim && is_write)));

    always_comb begin
        if (st_done)      biu_o_drdata = rdata_q;
        else if (in_itim) biu_o_drdata = biu_i_itim_rdata;
        else if (in_dtim) biu_o_drdata = biu_i_dtim_rdata;
        else              biu_o_drdata = DEFAULT_RDATA;
    end

endmodule

// File: tb/tb_biu2.sv
// ---------------------------------------------------------------------------
// tb_biu2 - directed self-checking bench for biu2 (TIMEOUT overridden to 4).
// ---------------------------------------------------------------------------
module tb_biu2;

    logic        clk;
    logic        rst;
    logic [31:0] iaddr, idata;
    logic        dreq;
    logic [31:0] daddr;
    logic [3:0]  dwmask;
    logic [31:0] dwdata, drdata;
    logic        halt, fault;
    logic [11:0] itim_addr, dtim_addr;
    logic [31:0] itim_rdata, dtim_rdata;
    logic [3:0]  dtim_wmask;
    logic [31:0] dtim_wdata;
    logic        mmio_valid;
    logic [31:0] mmio_addr;
    logic [3:0]  mmio_wmask;
    logic [31:0] mmio_wdata;
    logic        mmio_ready;
    logic [31:0] mmio_rdata;

    int tests = 0;
    int fails = 0;
    int hc, vc, fc;

    biu2 #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .biu_i_iaddr      (iaddr),
        .biu_o_idata      (idata),
        .biu_i_dreq       (dreq),
        .biu_i_daddr      (daddr),
        .biu_i_dwmask     (dwmask),
        .biu_i_dwdata     (dwdata),
        .biu_o_drdata     (drdata),
        .biu_o_halt       (halt),
        .biu_o_fault      (fault),
        .biu_o_itim_addr  (itim_addr),
        .biu_i_itim_rdata (itim_rdata),
        .biu_o_dtim_addr  (dtim_addr),
        .biu_o_dtim_wmask (dtim_wmask),
        .biu_o_dtim_wdata (dtim_wdata),
        .biu_i_dtim_rdata (dtim_rdata),
        .biu_o_mmio_valid (mmio_valid),
        .biu_o_mmio_addr  (mmio_addr),
        .biu_o_mmio_wmask (mmio_wmask),
        .biu_o_mmio_wdata (mmio_wdata),
        .biu_i_mmio_ready (mmio_ready),
        .biu_i_mmio_rdata (mmio_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        iaddr      = 32'h0000_0ABC;
        dreq       = 1'b0;
        daddr      = 32'h0;
        dwmask     = 4'h0;
        dwdata     = 32'h0;
        itim_rdata = 32'h1111_0000;
        dtim_rdata = 32'h2222_0000;
        mmio_ready = 1'b0;
        mmio_rdata = 32'h0;
        #2;
        check("rst_valid", mmio_valid, 0);
        check("rst_halt",  halt, 0);
        check("rst_fault", fault, 0);
        check("rst_mwmask", mmio_wmask, 0);
        check("itim_addr", itim_addr, 32'hABC);
        check("idata",     idata, 32'h1111_0000);
        dreq  = 1'b1;
        daddr = 32'h0000_2000;
        #1;
        check("rst_mmio_halt",  halt, 0);
        check("rst_mmio_valid", mmio_valid, 0);
        daddr = 32'h0000_8000;
        #1;
        check("rst_unmapped_fault", fault, 0);
        dreq = 1'b0;
        tick();
        rst = 1'b1;

        // DTIM write
        dreq = 1'b1; daddr = 32'h0000_1004; dwmask = 4'hF; dwdata = 32'hDEAD_BEEF;
        #1;
        check("dtim_addr",  dtim_addr, 32'h004);
        check("dtim_wmask", dtim_wmask, 4'hF);
        check("dtim_wdata", dtim_wdata, 32'hDEAD_BEEF);
        check("dtim_halt",  halt, 0);
        check("dtim_fault", fault, 0);
        tick();
        check("dtim_halt2", halt, 0);
        check("dtim_nomm",  mmio_valid, 0);
        dreq = 1'b0;
        #1;
        check("dtim_wmask_noreq", dtim_wmask, 0);

        // DTIM read at last word, then ITIM boundary read
        dreq = 1'b1; daddr = 32'h0000_1FFC; dwmask = 4'h0;
        #1;
        check("dtim_rd_data",  drdata, 32'h2222_0000);
        check("dtim_rd_addr",  dtim_addr, 32'hFFC);
        check("dtim_rd_wmask", dtim_wmask, 0);
        daddr = 32'h0000_0FFC;
        #1;
        check("itim_top_rd", drdata, 32'h1111_0000);
        check("itim_top_fault", fault, 0);
        tick();
        dreq = 1'b0;

        // MMIO read, ready in third REQ cycle
        dreq = 1'b1; daddr = 32'h0000_2010; dwmask = 4'h0;
        hc = 0;
        #1;
        check("mr_idle_halt",  halt, 1);
        check("mr_idle_valid", mmio_valid, 0);
        hc += int'(halt);
        tick();
        check("mr_valid0", mmio_valid, 1);
        check("mr_addr",   mmio_addr, 32'h010);
        check("mr_wmask",  mmio_wmask, 0);
        hc += int'(halt);
        tick();
        check("mr_valid1", mmio_valid, 1);
        hc += int'(halt);
        tick();
        mmio_ready = 1'b1; mmio_rdata = 32'h1234_5678;
        check("mr_valid2", mmio_valid, 1);
        hc += int'(halt);
        tick();
        mmio_ready = 1'b0; mmio_rdata = 32'h0;
        hc += int'(halt);
        check("mr_done_valid", mmio_valid, 0);
        check("mr_done_halt",  halt, 0);
        check("mr_done_data",  drdata, 32'h1234_5678);
        check("mr_done_fault", fault, 0);
        check("mr_halt_cycles", hc, 4);
        dreq = 1'b0;
        tick();
        check("mr_idle_after", mmio_valid, 0);
        mmio_ready = 1'b1;
        tick();
        check("ready_ignored", mmio_valid, 0);
        mmio_ready = 1'b0;

        // MMIO write at last word of region, ready in first REQ cycle
        dreq = 1'b1; daddr = 32'h0000_2FFC; dwmask = 4'h3; dwdata = 32'hA5A5_0001;
        tick();
        check("mw_valid", mmio_valid, 1);
        check("mw_addr",  mmio_addr, 32'hFFC);
        check("mw_wmask", mmio_wmask, 4'h3);
        check("mw_wdata", mmio_wdata, 32'hA5A5_0001);
        check("mw_dtimw", dtim_wmask, 0);
        dwdata = 32'h0;
        mmio_ready = 1'b1;
        #1;
        check("mw_wdata_stable", mmio_wdata, 32'hA5A5_0001);
        tick();
        mmio_ready = 1'b0;
        check("mw_done_halt",  halt, 0);
        check("mw_done_wmask", mmio_wmask, 0);
        check("mw_done_fault", fault, 0);
        dreq = 1'b0; dwmask = 4'h0;
        tick();

        // MMIO timeout (TIMEOUT = 4)
        dreq = 1'b1; daddr = 32'h0000_2020;
        vc = 0; fc = 0;
        tick();
        check("to_addr", mmio_addr, 32'h020);
        while (mmio_valid && vc < 20) begin
            vc++;
            fc += int'(fault);
            tick();
        end
        fc += int'(fault);
        check("to_done_fault", fault, 1);
        check("to_done_data",  drdata, 32'hCCCC_CCCC);
        check("to_done_halt",  halt, 0);
        dreq = 1'b0;
        tick();
        fc += int'(fault);
        check("to_fault_clear", fault, 0);
        check("to_valid_cycles", vc, 4);
        check("to_fault_pulses", fc, 1);
        check("to_idle_valid", mmio_valid, 0);

        // ready arriving in the last allowed cycle wins over timeout
        dreq = 1'b1; daddr = 32'h0000_2030;
        tick();
        tick();
        tick();
        tick();
        check("lr_valid_last", mmio_valid, 1);
        mmio_ready = 1'b1; mmio_rdata = 32'h0BAD_F00D;
        tick();
        mmio_ready = 1'b0;
        check("lr_fault", fault, 0);
        check("lr_data",  drdata, 32'h0BAD_F00D);
        check("lr_valid", mmio_valid, 0);
        dreq = 1'b0;
        tick();
        check("lr_fault_after", fault, 0);

        // Unmapped accesses
        dreq = 1'b1; daddr = 32'h0000_8000; dwmask = 4'h0;
        #1;
        check("um_fault", fault, 1);
        check("um_data",  drdata, 32'hCCCC_CCCC);
        check("um_halt",  halt, 0);
        tick();
        dreq = 1'b0;
        #1;
        check("um_fault_clear", fault, 0);
        dreq = 1'b1; daddr = 32'h0000_3000; dwmask = 4'hF;
        #1;
        check("um_edge_fault", fault, 1);
        check("um_edge_halt",  halt, 0);
        check("um_edge_dtimw", dtim_wmask, 0);
        tick();
        dreq = 1'b0;

        // ITIM data write faults, ITIM data read does not
        dreq = 1'b1; daddr = 32'h0000_0100; dwmask = 4'hF; dwdata = 32'h5555_5555;
        #1;
        check("iw_fault", fault, 1);
        check("iw_dtimw", dtim_wmask, 0);
        check("iw_mmiow", mmio_wmask, 0);
        check("iw_halt",  halt, 0);
        dwmask = 4'h0;
        #1;
        check("ir_fault", fault, 0);
        check("ir_data",  drdata, 32'h1111_0000);
        tick();
        dreq = 1'b0;

        // Reset during REQ
        dreq = 1'b1; daddr = 32'h0000_2004; dwmask = 4'hF; dwdata = 32'h0000_0077;
        tick();
        check("rr_valid", mmio_valid, 1);
        check("rr_halt",  halt, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rr_async_valid", mmio_valid, 0);
        check("rr_async_halt",  halt, 0);
        check("rr_async_wmask", mmio_wmask, 0);
        check("rr_async_fault", fault, 0);
        dreq = 1'b0; dwmask = 4'h0;
        tick();
        rst = 1'b1;
        tick();
        check("rr_idle", mmio_valid, 0);
        dreq = 1'b1; daddr = 32'h0000_2008;
        tick();
        check("rr_new_valid", mmio_valid, 1);
        check("rr_new_addr",  mmio_addr, 32'h008);
        check("rr_new_wmask", mmio_wmask, 0);
        mmio_ready = 1'b1; mmio_rdata = 32'hFEED_FACE;
        tick();
        mmio_ready = 1'b0;
        check("rr_new_data",  drdata, 32'hFEED_FACE);
        check("rr_new_halt",  halt, 0);
        check("rr_new_fault", fault, 0);
        dreq = 1'b0;
        tick();
        check("rr_end_valid", mmio_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
